// File: rtl/nios_system_btn_debounce_if.sv
// Purpose: bundles the raw button pins and the debounced level/strobe outputs of one button bank.
// Latency: wiring only, no logic.
// Backpressure: none; all strobes are fire-and-forget, single-cycle.
//
// Signals (all NUM_BTNS wide, one bit per button channel):
//   btn_raw       raw, asynchronous button pins (driven by the board / master side)
//   btn_level     debounced level, 1 = pressed (feeds the PIO in_port)
//   press_pulse   one-cycle strobe when a press is accepted
//   release_pulse one-cycle strobe when a release is accepted
//   long_pulse    one-cycle strobe, at most once per press, when the hold time is reached
interface nios_system_btn_debounce_if #(
    parameter int NUM_BTNS = 1
);
    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] press_pulse;
    logic [NUM_BTNS-1:0] release_pulse;
    logic [NUM_BTNS-1:0] long_pulse;

    // master: owns the raw pins and observes the classifier outputs
    modport master (
        output btn_raw,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

    // slave: the debouncer itself
    modport slave (
        input  btn_raw,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );
endinterface

// File: rtl/nios_system_btn_debounce.sv
// Purpose: per-button 2-flop synchroniser, debouncer and press/release/long-press classifier.
// Latency: DEBOUNCE_CYCLES+3 clocks from a clean raw edge to btn_level / press or release strobe.
// Backpressure: none; strobes are single-cycle and cannot be stalled.
//
// Ports:
//   clk    system clock, all state on its rising edge
//   reset  synchronous, active-high; returns every channel to RELEASED with outputs low
//   bus    slave modport of nios_system_btn_debounce_if (btn_raw in; btn_level,
//          press_pulse, release_pulse, long_pulse out), NUM_BTNS bits each
module nios_system_btn_debounce #(
    parameter int NUM_BTNS        = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    nios_system_btn_debounce_if.slave   bus
);

    // Both counters share one width sized for the larger of the two intervals.
    localparam int MAX_CYC = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Idle level of the raw pin; the synchroniser resets to it so that
    // leaving reset never looks like an edge.
    localparam logic INACTIVE = ACTIVE_LOW;

    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    logic [NUM_BTNS-1:0] sync1;
    logic [NUM_BTNS-1:0] sync2;
    logic [NUM_BTNS-1:0] pressed_now;

    logic [1:0]          state     [NUM_BTNS];
    logic [CNT_W-1:0]    deb_cnt   [NUM_BTNS];
    logic [CNT_W-1:0]    hold_cnt  [NUM_BTNS];
    logic [NUM_BTNS-1:0] long_done;

    logic [NUM_BTNS-1:0] level_q;
    logic [NUM_BTNS-1:0] press_q;
    logic [NUM_BTNS-1:0] release_q;
    logic [NUM_BTNS-1:0] long_q;

    // Normalised press: 1 means "button is being pushed" regardless of pin polarity.
    assign pressed_now = sync2 ^ {NUM_BTNS{ACTIVE_LOW}};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= {NUM_BTNS{INACTIVE}};
            sync2     <= {NUM_BTNS{INACTIVE}};
            long_done <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int i = 0; i < NUM_BTNS; i++) begin
                state[i]    <= ST_RELEASED;
                deb_cnt[i]  <= '0;
                hold_cnt[i] <= '0;
            end
        end else begin
            sync1 <= bus.btn_raw;
            sync2 <= sync1;

            // Strobes are high for exactly one cycle unless re-asserted below.
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;

            for (int i = 0; i < NUM_BTNS; i++) begin
                case (state[i])
                    ST_RELEASED: begin
                        if (pressed_now[i]) begin
                            state[i]   <= ST_PRESS_CHK;
                            deb_cnt[i] <= '0;
                        end
                    end

                    ST_PRESS_CHK: begin
                        if (!pressed_now[i]) begin
                            // Glitch: drop back without touching any output.
                            state[i] <= ST_RELEASED;
                        end else if (deb_cnt[i] == DEB_LAST) begin
                            state[i]     <= ST_PRESSED;
                            level_q[i]   <= 1'b1;
                            press_q[i]   <= 1'b1;
                            hold_cnt[i]  <= '0;
                            long_done[i] <= 1'b0;
                        end else begin
                            deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
                        end
                    end

                    ST_PRESSED: begin
                        if (!pressed_now[i]) begin
                            state[i]   <= ST_RELEASE_CHK;
                            deb_cnt[i] <= '0;
                        end else begin
                            // Saturate so a very long hold never wraps and re-fires.
                            if (hold_cnt[i] != LONG_LAST) begin
                                hold_cnt[i] <= hold_cnt[i] + CNT_ONE;
                            end
                            if ((hold_cnt[i] == LONG_LAST) && !long_done[i]) begin
                                long_q[i]    <= 1'b1;
                                long_done[i] <= 1'b1;
                            end
                        end
                    end

                    ST_RELEASE_CHK: begin
                        if (pressed_now[i]) begin
                            // Release bounce: resume the hold where it left off.
                            state[i] <= ST_PRESSED;
                        end else if (deb_cnt[i] == DEB_LAST) begin
                            state[i]     <= ST_RELEASED;
                            level_q[i]   <= 1'b0;
                            release_q[i] <= 1'b1;
                        end else begin
                            deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
                        end
                    end

                    default: begin
                        state[i] <= ST_RELEASED;
                    end
                endcase
            end
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;

endmodule

// File: doc/nios_system_btn_debounce.md
Name: nios_system_btn_debounce

Overview:
Per-button synchroniser, debouncer and press classifier for the active-low board push-buttons. It sits between the raw KEY pins and the button PIO in_port.
- btn_level drives the PIO in_port directly with a clean, glitch-free level, so the PIO edge capture fires once per physical press.
- One-cycle press, release and long-press strobes are also produced for hardware consumers such as the playback control logic.

Parameters:
NUM_BTNS, 1, number of independent button channels
DEBOUNCE_CYCLES, 500000, clocks the input must stay stable before a change is accepted (10 ms at 50 MHz); legal range ≥ 2
LONG_CYCLES, 50000000, clocks btn_level must stay high before long_pulse fires (1 s at 50 MHz); legal range ≥ 2
ACTIVE_LOW, 1, 1 means a raw input of 0 is a press; 0 means a raw input of 1 is a press

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_raw  input  NUM_BTNS  asynchronous raw button pins
btn_level  output  NUM_BTNS  debounced level, 1 = pressed; connects to PIO in_port
press_pulse  output  NUM_BTNS  1-cycle strobe when a press is accepted
release_pulse  output  NUM_BTNS  1-cycle strobe when a release is accepted
long_pulse  output  NUM_BTNS  1-cycle strobe, at most once per press, when the hold reaches LONG_CYCLES

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high. All state updates on posedge clk only.
- Reset values:
  - State: RELEASED; all counters 0; all outputs 0.
  - Synchroniser flops: the inactive raw level, i.e. 1 when ACTIVE_LOW=1.
  - A reset asserted mid-operation aborts any check or hold immediately. No pulse is emitted on reset entry or exit.
- Synchroniser: btn_raw → s1 → s2 (two flops per channel). Normalised press p = s2 XOR ACTIVE_LOW.
- Counter widths: each channel has deb_cnt and hold_cnt, each $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1) bits wide.
- Per-channel FSM, all channels fully independent:
  - RELEASED:
    - p=1 → PRESS_CHK, deb_cnt←0.
    - p=0 → stay.
  - PRESS_CHK:
    - p=0 → RELEASED, no output change (glitch rejected).
    - p=1 and deb_cnt==DEBOUNCE_CYCLES-1 → PRESSED; btn_level←1; press_pulse←1 for one cycle; hold_cnt←0; long_done←0.
    - Otherwise deb_cnt++.
  - PRESSED:
    - p=0 → RELEASE_CHK, deb_cnt←0.
    - p=1 → hold_cnt increments, saturating at LONG_CYCLES-1. When hold_cnt==LONG_CYCLES-1 and long_done=0: long_pulse←1 for one cycle, long_done←1.
  - RELEASE_CHK:
    - p=1 → PRESSED (bounce rejected). btn_level stays 1, hold_cnt and long_done are kept, no pulse.
    - p=0 and deb_cnt==DEBOUNCE_CYCLES-1 → RELEASED; btn_level←0; release_pulse←1 for one cycle.
    - Otherwise deb_cnt++; hold_cnt is frozen.
- Latency: for a clean raw edge, btn_level and press_pulse (or release_pulse) update on the (DEBOUNCE_CYCLES+3)th rising edge after the raw change (2 synchroniser + 1 FSM entry + DEBOUNCE_CYCLES check).
- long_pulse timing: long_pulse is asserted LONG_CYCLES clocks after press_pulse, provided btn_level stays 1 throughout.
- Pulse exclusivity: press_pulse, release_pulse and long_pulse are never asserted together on one channel. long_pulse can only occur in PRESSED, and only after press_pulse.
- Button held across reset: after reset deassertion the press is reported normally, DEBOUNCE_CYCLES+3 clocks later.
- All outputs are registered. There is no combinational path from btn_raw to any output.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=8, LONG_CYCLES=32, NUM_BTNS=2, ACTIVE_LOW=1.)
1. Clean press: btn_raw[0] 1→0 and held → btn_level[0]=1 and press_pulse[0]=1 for one cycle at edge 11. btn_raw[1] stays idle; all channel-1 outputs stay 0.
2. Bounce rejection: btn_raw[0] low for 5 clocks, high for 2, then low and held → no output until 11 edges after the final low; then exactly one press_pulse.
3. Release with bounce: from pressed, raw goes high 3 clocks, low 1, then high and held → btn_level stays 1 through the bounce. It falls and release_pulse fires exactly once, 11 edges after the final rise.
4. Long press: hold the press → long_pulse[0] fires once, 32 clocks after press_pulse, with no repeat while still held. A release followed by a new press re-arms it.
5. Reset mid-check: assert reset during PRESS_CHK with the button held → all outputs 0 during reset. After release, press_pulse fires 11 edges after reset deassertion, and no release_pulse appears.
6. Simultaneous channels: both buttons pressed on the same cycle → both press_pulse bits assert on the same edge; ch1 released early → only release_pulse[1] fires.
